i2c_slave_frame: RTL and testbench



---
 rtl/i2c_slave_frame.sv | 263 ++++++++++++++++++++++++++
 tb/tb_i2c_slave_frame.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_frame.sv
// I2C write slave for the FIR coefficient bank: 7-bit address match, per-byte
// ACK/NACK, fixed NBYTES frame committed atomically to data_out, frame-error pulse.
// Optional read-back of data_out is compiled in when I2C_READ_EN is defined.
module i2c_slave_frame #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h28,
  parameter int         NBYTES      = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  inout  tri                  scl_inout,
  inout  tri                  sda_inout,
  output logic [NBYTES*8-1:0] data_out,
  output logic                valid_out,
  output logic                start_out,
  output logic                stop_out,
  output logic                frame_err_out,
  output logic                busy_out
);

  localparam int CNT_W = $clog2(NBYTES + 1);

`ifdef I2C_READ_EN
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, NACK_WAIT, IGNORE, READ} state_t;
`else
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, NACK_WAIT, IGNORE} state_t;
`endif

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   past_scl_q, past_sda_q;
  logic                   scl, sda, scl_rise, scl_fall, start_det, stop_det;

  state_t                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   full_q, full_d;
  logic [CNT_W-1:0]       byte_cnt_q, byte_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [NBYTES*8-1:0]    stage_q, stage_d, data_q, data_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   busy_q, busy_d;
  logic                   valid_q, start_q, stop_q, err_q;
  logic                   commit, frame_err;
`ifdef I2C_READ_EN
  logic                   rd_q, rd_d;
  logic                   ack_ph_q, ack_ph_d;
  logic [7:0]             tx_q, tx_d;
  logic [CNT_W-1:0]       rd_idx_q, rd_idx_d, rd_nxt;

  // Byte idx of a frame word, byte 0 in the MSBs
  function automatic logic [7:0] pick_byte(input logic [NBYTES*8-1:0] d,
                                           input logic [CNT_W-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < NBYTES; i++)
      if (idx == CNT_W'(i)) b = d[(NBYTES-1-i)*8 +: 8];
    return b;
  endfunction
`endif

  // Open drain: only ever pull low; SCL is never driven
  assign sda_inout = sda_oe_q ? 1'b0 : 1'bz;

  assign scl       = scl_sync_q[SYNC_STAGES-1];
  assign sda       = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl & ~past_scl_q;
  assign scl_fall  = ~scl & past_scl_q;
  assign start_det = scl & past_sda_q & ~sda;
  assign stop_det  = scl & ~past_sda_q & sda;

  assign data_out      = data_q;
  assign valid_out     = valid_q;
  assign start_out     = start_q;
  assign stop_out      = stop_q;
  assign frame_err_out = err_q;
  assign busy_out      = busy_q;

  // Synchronise the bus lines and keep one cycle of history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      past_scl_q <= 1'b1;
      past_sda_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_inout};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_inout};
      past_scl_q <= scl;
      past_sda_q <= sda;
    end
  end

  // State and datapath registers plus the registered event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      full_q     <= 1'b0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      stage_q    <= '0;
      data_q     <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef I2C_READ_EN
      rd_q       <= 1'b0;
      ack_ph_q   <= 1'b0;
      tx_q       <= '0;
      rd_idx_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      full_q     <= full_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      stage_q    <= stage_d;
      data_q     <= data_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      valid_q    <= commit;
      start_q    <= start_det;
      stop_q     <= stop_det;
      err_q      <= frame_err;
`ifdef I2C_READ_EN
      rd_q       <= rd_d;
      ack_ph_q   <= ack_ph_d;
      tx_q       <= tx_d;
      rd_idx_q   <= rd_idx_d;
`endif
    end
  end

  // Next-state logic; bus START/STOP override any SCL edge seen in the same cycle
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    full_d     = full_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    stage_d    = stage_q;
    data_d     = data_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    commit     = 1'b0;
    frame_err  = (start_det | stop_det) & busy_q & (byte_cnt_q != '0) &
                 (byte_cnt_q < CNT_W'(NBYTES));
`ifdef I2C_READ_EN
    rd_d       = rd_q;
    ack_ph_d   = ack_ph_q;
    tx_d       = tx_q;
    rd_idx_d   = rd_idx_q;
    rd_nxt     = (rd_idx_q == CNT_W'(NBYTES-1)) ? '0 : rd_idx_q + 1'b1;
`endif
    if (start_det) begin
      state_d    = ADDR;
      bit_cnt_d  = '0;
      full_d     = 1'b0;
      byte_cnt_d = '0;
      stage_d    = '0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
`ifdef I2C_READ_EN
      rd_d       = 1'b0;
`endif
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      full_d    = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      if (scl_rise && (state_q == ADDR || state_q == DATA)) begin
        shift_d   = {shift_q[6:0], sda};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) full_d = 1'b1;
      end
      case (state_q)
        ADDR: if (scl_fall && full_q) begin
          full_d = 1'b0;
          if (shift_q[7:1] == SLAVE_ADDR && !shift_q[0]) begin
            state_d  = ADDR_ACK;
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
`ifdef I2C_READ_EN
          end else if (shift_q[7:1] == SLAVE_ADDR) begin
            state_d  = ADDR_ACK;
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
            rd_d     = 1'b1;
`endif
          end else begin
            state_d = IGNORE;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          sda_oe_d = 1'b0;
          state_d  = DATA;
`ifdef I2C_READ_EN
          if (rd_q) begin
            state_d   = READ;
            rd_idx_d  = '0;
            tx_d      = pick_byte(data_q, '0);
            sda_oe_d  = ~tx_d[7];
            bit_cnt_d = '0;
            ack_ph_d  = 1'b0;
          end
`endif
        end
        DATA: if (scl_fall && full_q) begin
          full_d = 1'b0;
          if (byte_cnt_q < CNT_W'(NBYTES)) begin
            for (int i = 0; i < NBYTES; i++)
              if (byte_cnt_q == CNT_W'(i)) stage_d[(NBYTES-1-i)*8 +: 8] = shift_q;
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = DATA_ACK;
            sda_oe_d   = 1'b1;
            if (byte_cnt_q == CNT_W'(NBYTES-1)) begin
              commit = 1'b1;
              data_d = stage_d;
            end
          end else begin
            state_d = NACK_WAIT;
          end
        end
        DATA_ACK: if (scl_fall) begin
          sda_oe_d = 1'b0;
          state_d  = DATA;
        end
        NACK_WAIT: if (scl_fall) state_d = DATA;
`ifdef I2C_READ_EN
        READ: begin
          if (ack_ph_q) begin
            if (scl_rise && sda) begin
              state_d = IGNORE;
            end else if (scl_fall) begin
              rd_idx_d  = rd_nxt;
              tx_d      = pick_byte(data_q, rd_nxt);
              sda_oe_d  = ~tx_d[7];
              bit_cnt_d = '0;
              ack_ph_d  = 1'b0;
            end
          end else if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              ack_ph_d = 1'b1;
            end else begin
              tx_d      = {tx_q[6:0], 1'b0};
              sda_oe_d  = ~tx_q[6];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_frame.sv
// Bench for i2c_slave_frame: open-drain bus model with a bit-banged master,
// table of write frames plus hand-written restart, read and reset sequences.
module tb_i2c_slave_frame;

  localparam int Q = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_scl, m_sda;
  wire         scl_w, sda_w;
  logic [31:0] data_out;
  logic        valid_out, start_out, stop_out, frame_err_out, busy_out;

  assign scl_w = m_scl ? 1'bz : 1'b0;
  assign sda_w = m_sda ? 1'bz : 1'b0;
  pullup (scl_w);
  pullup (sda_w);

  i2c_slave_frame dut (
    .clk(clk), .rst(rst), .scl_inout(scl_w), .sda_inout(sda_w),
    .data_out(data_out), .valid_out(valid_out), .start_out(start_out),
    .stop_out(stop_out), .frame_err_out(frame_err_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  int valid_hi = 0, start_cnt = 0, stop_cnt = 0, err_cnt = 0, dut_low = 0, busy_hi = 0;
  always @(negedge clk) begin
    if (valid_out === 1'b1)     valid_hi++;
    if (start_out === 1'b1)     start_cnt++;
    if (stop_out === 1'b1)      stop_cnt++;
    if (frame_err_out === 1'b1) err_cnt++;
    if (busy_out === 1'b1)      busy_hi++;
    if (sda_w !== 1'b1 && m_sda) dut_low++;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wq(Q);
    m_scl = 1'b1; wq(Q);
    m_sda = 1'b0; wq(Q);
    m_scl = 1'b0; wq(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wq(Q);
    m_scl = 1'b1; wq(Q);
    m_sda = 1'b1; wq(2*Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    wq(Q);
    m_scl = 1'b1; wq(2*Q);
    m_scl = 1'b0; wq(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; wq(Q);
    m_scl = 1'b1; wq(Q);
    ack = (sda_w === 1'b0);
    wq(Q);
    m_scl = 1'b0; wq(Q);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wq(Q);
      m_scl = 1'b1; wq(Q);
      b[i] = (sda_w === 1'b0) ? 1'b0 : 1'b1;
      wq(Q);
      m_scl = 1'b0; wq(Q);
    end
    m_sda = ~mack; wq(Q);
    m_scl = 1'b1;  wq(2*Q);
    m_scl = 1'b0;  wq(Q);
    m_sda = 1'b1;
  endtask

  typedef struct packed {
    logic [7:0]  addr;
    logic [2:0]  nb;
    logic [47:0] bytes;
    logic [5:0]  exp_ack;
    logic [31:0] exp_data;
    logic [3:0]  exp_valid;
    logic [3:0]  exp_err;
  } vec_t;

  vec_t vecs [4];

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ack;
    logic [5:0]  got;
    logic [47:0] bs;
    logic [7:0]  rb;
    logic [31:0] rd_word;
    int v0, s0, p0, e0, d0, b0;

    vecs[0] = '{8'h50, 3'd4, 48'hDEADBEEF0000, 6'b111110, 32'hDEADBEEF, 4'd1, 4'd0};
    vecs[1] = '{8'h52, 3'd4, 48'h112233440000, 6'b000000, 32'hDEADBEEF, 4'd0, 4'd0};
    vecs[2] = '{8'h50, 3'd2, 48'h112200000000, 6'b111000, 32'hDEADBEEF, 4'd0, 4'd1};
    vecs[3] = '{8'h50, 3'd5, 48'h102030405000, 6'b111110, 32'h10203040, 4'd1, 4'd0};

    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    wq(5);
    chk("rst_data",  data_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_start", start_out, 0);
    chk("rst_stop",  stop_out, 0);
    chk("rst_err",   frame_err_out, 0);
    chk("rst_busy",  busy_out, 0);
    chk("rst_sda",   sda_w, 1);
    rst = 1'b0;
    wq(5);

    for (int i = 0; i < 4; i++) begin
      v0 = valid_hi; s0 = start_cnt; p0 = stop_cnt; e0 = err_cnt; d0 = dut_low; b0 = busy_hi;
      got = '0;
      bs  = vecs[i].bytes;
      i2c_start();
      write_byte(vecs[i].addr, ack);
      got[5] = ack;
      for (int k = 0; k < int'(vecs[i].nb); k++) begin
        write_byte(bs[47-8*k -: 8], ack);
        got[4-k] = ack;
      end
      i2c_stop();
      chk($sformatf("v%0d_acks", i),  got, vecs[i].exp_ack);
      chk($sformatf("v%0d_data", i),  data_out, vecs[i].exp_data);
      chk($sformatf("v%0d_valid", i), valid_hi - v0, vecs[i].exp_valid);
      chk($sformatf("v%0d_err", i),   err_cnt - e0, vecs[i].exp_err);
      chk($sformatf("v%0d_start", i), start_cnt - s0, 1);
      chk($sformatf("v%0d_stop", i),  stop_cnt - p0, 1);
      chk($sformatf("v%0d_sdadrv", i), (dut_low - d0) != 0, vecs[i].exp_ack[5]);
      chk($sformatf("v%0d_busyseen", i), (busy_hi - b0) != 0, vecs[i].exp_ack[5]);
      chk($sformatf("v%0d_busyend", i), busy_out, 0);
    end

    // Partial frame cut short by a repeated START, then a full frame
    v0 = valid_hi; s0 = start_cnt; e0 = err_cnt;
    i2c_start();
    write_byte(8'h50, ack); chk("rs_addr1_ack", ack, 1);
    write_byte(8'hAA, ack); chk("rs_aa_ack", ack, 1);
    i2c_start();
    chk("rs_err_at_restart", err_cnt - e0, 1);
    write_byte(8'h50, ack); chk("rs_addr2_ack", ack, 1);
    write_byte(8'h01, ack);
    write_byte(8'h02, ack);
    write_byte(8'h03, ack);
    write_byte(8'h04, ack); chk("rs_b4_ack", ack, 1);
    i2c_stop();
    chk("rs_start", start_cnt - s0, 2);
    chk("rs_err", err_cnt - e0, 1);
    chk("rs_valid", valid_hi - v0, 1);
    chk("rs_data", data_out, 32'h01020304);

    // Load a known word, then read it back
    i2c_start();
    write_byte(8'h50, ack);
    write_byte(8'h10, ack);
    write_byte(8'h20, ack);
    write_byte(8'h30, ack);
    write_byte(8'h40, ack);
    i2c_stop();
    chk("rdprep_data", data_out, 32'h10203040);
    v0 = valid_hi; e0 = err_cnt; d0 = dut_low;
    i2c_start();
    write_byte(8'h51, ack);
`ifdef I2C_READ_EN
    chk("rd_addr_ack", ack, 1);
    for (int k = 0; k < 4; k++) begin
      read_byte(k != 3, rb);
      rd_word = {rd_word[23:0], rb};
    end
    wq(Q);
    chk("rd_word", rd_word, 32'h10203040);
    chk("rd_released", sda_w, 1);
`else
    chk("rd_addr_nack", ack, 0);
    chk("rd_no_drive", dut_low - d0, 0);
    rd_word = 32'h0;
`endif
    i2c_stop();
    chk("rd_valid", valid_hi - v0, 0);
    chk("rd_err", err_cnt - e0, 0);
    chk("rd_data_kept", data_out, 32'h10203040);
    chk("rd_busyend", busy_out, 0);

    // Reset while the slave is pulling SDA low for a data ACK
    v0 = valid_hi;
    i2c_start();
    write_byte(8'h50, ack);
    for (int i = 7; i >= 0; i--) send_bit(1'b1);
    m_sda = 1'b1;
    wq(2);
    chk("mr_ack_driven", sda_w, 0);
    rst = 1'b1;
    wq(1);
    chk("mr_sda_released", sda_w, 1);
    chk("mr_busy", busy_out, 0);
    chk("mr_data", data_out, 0);
    rst = 1'b0;
    i2c_stop();
    chk("mr_valid", valid_hi - v0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
